// File: rtl/gpu_norm_pkg.sv
// Shared types, default parameters and helpers for the gpu_normalise block.
// Contents:
//   norm_state_e  - FSM state enum (IDLE, SCAN, DONE)
//   DEF_STEP      - default bits examined per scan cycle
//   DEF_NORM_POS  - default target bit position of the leading one
//   NGRP, GW      - group count and group counter width for the default STEP
//   norm_count()  - signed shift count that moves bit msb_index to norm_pos
package gpu_norm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } norm_state_e;

    localparam int unsigned DEF_STEP     = 4;
    localparam int unsigned DEF_NORM_POS = 22;
    localparam int unsigned NGRP         = 32 / DEF_STEP;
    localparam int unsigned GW           = $clog2(NGRP);

    // Positive result means shift right, negative means shift left.
    function automatic logic [31:0] norm_count(input logic [4:0] msb_index,
                                               input int unsigned norm_pos);
        return 32'(int'({27'b0, msb_index}) - int'(norm_pos));
    endfunction

endpackage

// File: rtl/gpu_norm_grp_enc.sv
// Combinational leading-one detector for one STEP-bit group.
// Ports:
//   grp  in   [STEP-1:0]  group bits, MSB first in significance
//   any  out  1           group is non-zero
//   lz   out  [LZW-1:0]   leading zeros above the first one (0 when any=0)
module gpu_norm_grp_enc #(
    parameter  int unsigned STEP = 4,
    localparam int unsigned LZW  = (STEP > 1) ? $clog2(STEP) : 1
) (
    input  logic [STEP-1:0] grp,
    output logic            any,
    output logic [LZW-1:0]  lz
);

    // Ascending scan so the highest set bit writes last and wins.
    always_comb begin
        any = |grp;
        lz  = '0;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (grp[i]) begin
                lz = LZW'(STEP - 1 - i);
            end
        end
    end

endmodule

// File: rtl/gpu_normalise.sv
// Iterative normaliser: finds the leading one of a 32-bit operand, STEP bits
// per cycle from the MSB, and returns the signed shift count that moves it to
// bit NORM_POS (positive = shift right, negative = shift left).
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   norm_start / normd    request and operand, accepted only while norm_ready
//   norm_ready            high in IDLE only
//   norm_valid / norm_ack result handshake; result held until acknowledged
//   normq                 signed count msb_index - NORM_POS
//   norm_zero             operand was zero (normq = 0)
// Build option: GPU_NORM_EARLY_EXIT_EN ends the scan on the first non-zero
// group; without it the scan always takes 32/STEP cycles.
module gpu_normalise
    import gpu_norm_pkg::*;
#(
    parameter int unsigned STEP     = DEF_STEP,
    parameter int unsigned NORM_POS = DEF_NORM_POS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        norm_start,
    input  logic [31:0] normd,
    output logic        norm_ready,
    output logic        norm_valid,
    input  logic        norm_ack,
    output logic [31:0] normq,
    output logic        norm_zero
);

    localparam int unsigned GRP_N = 32 / STEP;
    localparam int unsigned CNT_W = (GRP_N > 1) ? $clog2(GRP_N) : 1;
    localparam int unsigned LZW   = (STEP > 1) ? $clog2(STEP) : 1;

    norm_state_e       state, state_nxt;
    logic [CNT_W-1:0]  grp_cnt, grp_cnt_nxt;
    logic [31:0]       opnd, opnd_nxt;
    logic              found, found_nxt;
    logic [4:0]        msb, msb_nxt;
    logic [31:0]       normq_nxt;
    logic              norm_zero_nxt, norm_valid_nxt, norm_ready_nxt;

    logic              grp_any;
    logic [LZW-1:0]    grp_lz;
    logic [4:0]        msb_here;
    logic              hit;
    logic [4:0]        hit_msb;
    logic              done_now;

    // Operand shifts left each scan cycle, so the current group is always on top.
    gpu_norm_grp_enc #(.STEP(STEP)) u_grp_enc (
        .grp (opnd[31 -: STEP]),
        .any (grp_any),
        .lz  (grp_lz)
    );

    assign msb_here = 5'(32'd31 - 32'(grp_cnt) * 32'(STEP) - 32'(grp_lz));

    // State and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grp_cnt    <= '0;
            opnd       <= '0;
            found      <= 1'b0;
            msb        <= '0;
            normq      <= '0;
            norm_zero  <= 1'b0;
            norm_valid <= 1'b0;
            norm_ready <= 1'b1;
        end else begin
            state      <= state_nxt;
            grp_cnt    <= grp_cnt_nxt;
            opnd       <= opnd_nxt;
            found      <= found_nxt;
            msb        <= msb_nxt;
            normq      <= normq_nxt;
            norm_zero  <= norm_zero_nxt;
            norm_valid <= norm_valid_nxt;
            norm_ready <= norm_ready_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt      = state;
        grp_cnt_nxt    = grp_cnt;
        opnd_nxt       = opnd;
        found_nxt      = found;
        msb_nxt        = msb;
        normq_nxt      = normq;
        norm_zero_nxt  = norm_zero;
        norm_valid_nxt = norm_valid;
        norm_ready_nxt = norm_ready;
        hit            = found | grp_any;
        hit_msb        = found ? msb : msb_here;
        done_now       = 1'b0;

        case (state)
            IDLE: begin
                if (norm_start) begin
                    state_nxt      = SCAN;
                    opnd_nxt       = normd;
                    grp_cnt_nxt    = '0;
                    found_nxt      = 1'b0;
                    msb_nxt        = '0;
                    norm_ready_nxt = 1'b0;
                end
            end
            SCAN: begin
                opnd_nxt    = opnd << STEP;
                grp_cnt_nxt = grp_cnt + CNT_W'(1);
                if (grp_any && !found) begin
                    found_nxt = 1'b1;
                    msb_nxt   = msb_here;
                end
`ifdef GPU_NORM_EARLY_EXIT_EN
                done_now = grp_any || (grp_cnt == CNT_W'(GRP_N - 1));
`else
                done_now = (grp_cnt == CNT_W'(GRP_N - 1));
`endif
                if (done_now) begin
                    state_nxt      = DONE;
                    norm_valid_nxt = 1'b1;
                    norm_zero_nxt  = !hit;
                    normq_nxt      = hit ? norm_count(hit_msb, NORM_POS) : '0;
                end
            end
            DONE: begin
                // A start coinciding with the ack is dropped: state is still DONE.
                if (norm_ack) begin
                    state_nxt      = IDLE;
                    norm_valid_nxt = 1'b0;
                    norm_ready_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
